// File: rtl/tb_fifo_pkg.sv
// Shared types and constants for the aFIFO read-side drain engine.
package tb_fifo_pkg;

    localparam int DATA_W      = 8;
    localparam int STALL_LIMIT = 255;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_e;

    // Saturating step for the 8-bit stall watchdog.
    function automatic logic [7:0] stall_step(input logic [7:0] cnt);
        return (cnt == 8'(STALL_LIMIT)) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// aFIFO read port plus downstream valid/ready stream, seen from the drain engine.
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  empty, data_in, m_ready,
        output pop, m_valid, m_data
    );

    modport slave (
        output empty, data_in, m_ready,
        input  pop, m_valid, m_data
    );
endinterface

// File: rtl/skid_fifo.sv
// Circular skid buffer with explicit occupancy; head entry is presented directly.
module skid_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [OCC_W-1:0]      occ_reg;
    logic [OCC_W-1:0]      occ_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Simultaneous write and read leave the occupancy unchanged.
    always_comb begin
        occ_next = occ_reg;
        if (wr_en && !rd_en) begin
            occ_next = occ_reg + 1'b1;
        end else if (!wr_en && rd_en) begin
            occ_next = occ_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_reg[tail_reg] <= wr_data;
                tail_reg          <= ptr_inc(tail_reg);
            end
            if (rd_en) begin
                head_reg <= ptr_inc(head_reg);
            end
            occ_reg <= occ_next;
        end
    end

    assign rd_data = mem_reg[head_reg];
    assign occ     = occ_reg;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pops the aFIFO under a credit limit, buffers captured
// words in a skid buffer and streams them downstream with a stall watchdog.
module fifo_rd_drain
    import tb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(data_t),
    parameter int SKID_DEPTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_rd_drain_if.master      link,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 err_stall
);
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    drain_state_e         state_reg;
    drain_state_e         state_next;
    logic                 inflight_reg;
    logic [OCC_W-1:0]     occ;
    logic [OCC_W:0]       pending;
    logic                 accept;
    logic [7:0]           stall_reg;
    logic [7:0]           stall_next;
    logic                 err_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Credit counts words already owed to the buffer: registered occupancy
    // plus the word whose data arrives this cycle.
    assign pending = {1'b0, occ} + (OCC_W + 1)'(inflight_reg);
    assign link.pop = (state_reg == ST_RUN) && !link.empty &&
                      (pending < (OCC_W + 1)'(SKID_DEPTH));

    assign link.m_valid = (occ != '0);
    assign accept       = link.m_valid && link.m_ready;

    skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_reg),
        .wr_data (link.data_in),
        .rd_en   (accept),
        .rd_data (link.m_data),
        .occ     (occ)
    );

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        stall_next = 8'd0;
        case (state_reg)
            ST_IDLE: begin
                if (enable) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_next = ST_RUN;
                end else if (!inflight_reg && (occ == '0)) begin
                    state_next = ST_IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (link.m_valid && !link.m_ready) begin
            stall_next = stall_step(stall_reg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            inflight_reg <= 1'b0;
            cnt_reg      <= '0;
            stall_reg    <= 8'd0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= link.pop;
            if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            stall_reg <= stall_next;
            if (stall_next == 8'(STALL_LIMIT)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign word_cnt  = cnt_reg;
    assign err_stall = err_reg;

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain engine for the aFIFO read port. It issues pops while the FIFO is non-empty and captures `data_out` one cycle later. Captured words go into a small skid buffer, which presents them downstream on a valid/ready stream. The block runs entirely in the read clock domain, counts delivered words, and flags protocol violations. It is the consumer counterpart to the write-side push logic.

## Interface
- `DATA_WIDTH`, 8: word width; must match `data_t` in `tb_fifo_pkg`.
- `SKID_DEPTH`, 3: skid buffer entries. Minimum 2; 3 sustains one word per cycle.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

- `clk` in 1: read-domain clock.
- `rst` in 1: reset, asynchronous assert, active-low; synchronous deassert is supplied externally.
- `enable` in 1: level request to drain the FIFO.
- `empty` in 1: aFIFO read-side empty flag.
- `pop` out 1: aFIFO read strobe, combinational.
- `data_in` in DATA_WIDTH: aFIFO `data_out`, valid the cycle after `pop`.
- `m_valid` out 1: downstream word valid, registered.
- `m_data` out DATA_WIDTH: downstream word, registered.
- `m_ready` in 1: downstream accept.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle pulse on DRAIN→IDLE.
- `word_cnt` out CNT_WIDTH: words accepted downstream since reset; wraps.
- `err_stall` out 1: sticky; set when `m_valid && !m_ready` persists 256 cycles.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE→RUN when `enable`=1.
  - RUN→DRAIN when `enable`=0.
  - DRAIN→RUN when `enable`=1 again.
  - DRAIN→IDLE when in-flight=0 and skid occupancy=0. `done` pulses for one cycle on this transition.
- Pop rule: `pop = (state==RUN) && !empty && (occ + inflight) < SKID_DEPTH`.
  - The rule never pops on `empty`, so FIFO underflow is structurally impossible.
  - The credit count uses the registered `occ`, not `occ` minus the same-cycle accept.
- `inflight` is a 1-bit register equal to the previous cycle's `pop`. When `inflight`=1, `data_in` is written into the skid tail at the clock edge.
- Skid buffer is a circular buffer with head/tail pointers of width $clog2(SKID_DEPTH) and a separate `occ` counter (0..SKID_DEPTH).
  - Pointers wrap from SKID_DEPTH-1 to 0.
  - Same-cycle write and accept: `occ` is unchanged and both pointers advance.
- `m_valid = (occ != 0)`; `m_data` = head entry. The head may only advance on `m_valid && m_ready`.
- `m_data` must remain stable while `m_valid && !m_ready`.
- `word_cnt` increments on each `m_valid && m_ready` and wraps from 2^CNT_WIDTH-1 to 0.
- Stall watchdog: an 8-bit counter.
  - Increments while `m_valid && !m_ready`; clears otherwise.
  - Sets `err_stall` when it saturates at 255.
  - `err_stall` clears only on reset.
- DRAIN finishes delivering an already-issued pop and all buffered words; no new pops are issued.

## Timing
- Reset values: state=IDLE, `pop`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `word_cnt`=0, `err_stall`=0, `occ`=0, `inflight`=0, pointers=0.
- Reset asserted mid-operation clears everything immediately. Buffered words are discarded.
- Latency: `pop` high in cycle N, `data_in` sampled at the end of N+1, `m_valid` high in N+2.
- Throughput: with `m_ready` held at 1 and `empty`=0, `pop` stays high every cycle from the second RUN cycle onward (steady state occ=1, inflight=1).
- `enable` deasserted in the same cycle as a pop: that pop is still issued, since the state is still RUN. Its word is delivered in DRAIN.
- `empty` rising while in flight has no effect on the in-flight word.

## Structure
- `tb_fifo_pkg` holds `data_t`, the FSM state enum `drain_state_e`, and the constant `STALL_LIMIT`=255.
- One sub-module: `skid_fifo`, the circular buffer with `occ`, write/accept ports and no pop logic.
- The FSM, credit check, counters and watchdog are implemented in `fifo_rd_drain`.

## Test plan
- Basic drain:
  - Stimulus: the FIFO model is preloaded with 0x00..0x0A (11 words), `m_ready`=1, then `enable`=1.
  - Response: `m_data` sequence 0x00..0x0A; first `m_valid` 2 cycles after the first `pop`; `word_cnt`=11; no `pop` while `empty`.
- Backpressure:
  - Stimulus: 20 words, `m_ready` toggling 1/0 every cycle.
  - Response: `occ` never exceeds 3, no word lost or duplicated, `m_data` stable in every stalled cycle.
- Empty FIFO:
  - Stimulus: `enable`=1 with `empty`=1 held for 50 cycles.
  - Response: `pop` stays 0, `m_valid` stays 0, state=RUN, `word_cnt`=0.
- Drain and done:
  - Stimulus: `enable` drops while inflight=1 and occ=2.
  - Response: exactly 3 further words delivered, then a one-cycle `done`, then `busy`=0.
- Stall watchdog:
  - Stimulus: one word buffered, `m_ready`=0 for 300 cycles.
  - Response: `err_stall` rises on stall cycle 256 and stays high after `m_ready` returns.
- Reset mid-stream:
  - Stimulus: `rst` low for 1 cycle during a 16-word drain.
  - Response: all outputs return to reset values in the same cycle; no `pop` until `enable` is re-evaluated in IDLE.
